wrapper_reg_arbiter: RTL and testbench
======================================

Name: wrapper_reg_arbiter

Overview:
- Two-requester arbiter that shares one simple register-protocol target (addr / read_en / write_en / byte_strobe / wdata / rdata / wready / rready) between master ports m0 and m1.
- Typical pairing: AHB-to-register interface on m0, accelerator-side config sequencer on m1.
- Round-robin arbitration with zero-cycle grant when idle; ownership is held until the transfer completes.
- A watchdog force-completes any transfer the target never acknowledges.

Parameters:
- ADDRWIDTH, 12, register address width on all ports.
- TIMEOUT, 16, number of un-acknowledged target cycles before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEADBEEF, read data returned on a timed-out read.

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset, synchronous, active-low
- m0_addr / m1_addr  in  ADDRWIDTH  requester address
- m0_read_en / m1_read_en  in  1  read request, held until ready
- m0_write_en / m1_write_en  in  1  write request, held until ready
- m0_byte_strobe / m1_byte_strobe  in  4  byte lanes
- m0_wdata / m1_wdata  in  32  write data
- m0_rdata / m1_rdata  out  32  read data
- m0_wready / m1_wready  out  1  write complete
- m0_rready / m1_rready  out  1  read complete
- s_addr  out  ADDRWIDTH  target address
- s_read_en  out  1  target read enable
- s_write_en  out  1  target write enable
- s_byte_strobe  out  4  target byte lanes
- s_wdata  out  32  target write data
- s_rdata  in  32  target read data
- s_wready  in  1  target write ready
- s_rready  in  1  target read ready
- grant  out  2  one-hot current owner; 00 = none
- timeout_pulse  out  1  one-cycle flag on forced completion

Behaviour:
- Definitions:
  - reqN = mN_read_en | mN_write_en.
  - If a requester asserts both enables, the transfer is a write; s_read_en is forced to 0.
- State register values: IDLE, OWN0, OWN1. Also a registered last-served pointer `last` and a timeout counter `cnt` of width $clog2(TIMEOUT+1).
- Reset (hresetn=0 sampled at hclk edge): state=IDLE, last=1 (m0 has first priority), cnt=0.
- Outputs during reset and when no grant:
  - grant=00, timeout_pulse=0.
  - All mN_wready / mN_rready = 0; mN_rdata = 0.
  - s_read_en = s_write_en = 0.
  - s_addr, s_byte_strobe and s_wdata = 0.
- Grant selection (combinational):
  - OWNx: grant=x.
  - IDLE with one requester: grant goes to that requester.
  - IDLE with both requesting: grant goes to the requester other than `last`.
  - IDLE with none requesting: grant=00.
- Granted requester:
  - Its addr, enables, strobe and wdata drive the s_ outputs in the same cycle.
  - mN_wready = s_wready & write; mN_rready = s_rready & read.
  - mN_rdata = s_rdata.
- Non-granted requester: ready outputs are 0, so it stalls with its request held. Its rdata output is 0.
- Completion:
  - Normal: granted write with s_wready=1, or granted read with s_rready=1.
  - Forced: timeout (below).
  - On completion: state becomes IDLE, last becomes the granted requester, cnt becomes 0.
  - Back-to-back: a requester may present a new request in the cycle after completion. It is arbitrated afresh, so if the other requester is waiting, the other one wins.
- Not complete in a granted cycle: state becomes OWNx and cnt increments.
- Transfer withdrawn while in OWNx (reqx=0, protocol violation): state becomes IDLE, cnt becomes 0, last is unchanged, no target enable is driven.
- Timeout (TIMEOUT>0), when state=OWNx and cnt==TIMEOUT:
  - s_read_en = s_write_en = 0 in that cycle.
  - The matching mx ready output = 1 for that cycle.
  - On reads, mx_rdata = ERR_RDATA.
  - timeout_pulse=1 for that cycle.
  - Then normal completion update applies.
  - Net effect: the target sees TIMEOUT+? no — the target sees exactly TIMEOUT enabled cycles; the requester completes on cycle TIMEOUT+1.
- Combinational paths: req to s_* and s_ready to mN_ready are combinational and have zero-cycle latency. All state changes occur on the hclk edge.
- Reset mid-transfer: ownership is abandoned; the first cycle after reset behaves as IDLE.

Test Plan:
- Single write: m0 write addr 0x010, wdata 0x12345678, strobe 1111, s_wready=1 -> same cycle grant=01, s_write_en=1, s_addr=0x010, m0_wready=1; next cycle (no request) grant=00, s_write_en=0.
- Fairness: m0 and m1 both issue 4 back-to-back reads, s_rready=1, s_rdata=addr -> service order m0,m1,m0,m1,… one transfer per cycle; each mN_rdata matches its own addr; the losing requester sees rready=0.
- Hold: m1 write with s_wready=0 for 3 cycles; m0 read arrives in cycle 2 -> s_ outputs stay m1 for 4 cycles and m0_rready=0 throughout; m0 is granted in cycle 5.
- Timeout: TIMEOUT=4, m0 read, s_rready stuck 0 -> s_read_en=1 for cycles 1-4; cycle 5 has s_read_en=0, m0_rready=1, m0_rdata=0xDEADBEEF, timeout_pulse=1; cycle 6 has timeout_pulse=0.
- Reset mid-operation: state OWN1 with wready low, hresetn=0 one cycle -> after the edge grant=00 and s enables=0; with both requesting next, m0 wins (last=1).
- Illegal both-enables: m0 read_en=write_en=1, s_wready=1, s_rready=0 -> s_write_en=1, s_read_en=0, m0_wready=1, m0_rready=0.

Source files
------------

// File: rtl/wrapper_reg_arbiter.sv
// Round-robin arbiter sharing one register-protocol target between two masters.
// Ownership is held until the target acknowledges, or until the watchdog forces completion.
module wrapper_reg_arbiter #(
    parameter int          ADDRWIDTH = 12,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [ADDRWIDTH-1:0] m0_addr,
    input  logic                 m0_read_en,
    input  logic                 m0_write_en,
    input  logic [3:0]           m0_byte_strobe,
    input  logic [31:0]          m0_wdata,
    output logic [31:0]          m0_rdata,
    output logic                 m0_wready,
    output logic                 m0_rready,
    input  logic [ADDRWIDTH-1:0] m1_addr,
    input  logic                 m1_read_en,
    input  logic                 m1_write_en,
    input  logic [3:0]           m1_byte_strobe,
    input  logic [31:0]          m1_wdata,
    output logic [31:0]          m1_rdata,
    output logic                 m1_wready,
    output logic                 m1_rready,
    output logic [ADDRWIDTH-1:0] s_addr,
    output logic                 s_read_en,
    output logic                 s_write_en,
    output logic [3:0]           s_byte_strobe,
    output logic [31:0]          s_wdata,
    input  logic [31:0]          s_rdata,
    input  logic                 s_wready,
    input  logic                 s_rready,
    output logic [1:0]           grant,
    output logic                 timeout_pulse
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            req0, req1;
    logic [1:0]      gnt;
    logic            active, sel_req, sel_wr, sel_rd, tmo, done;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [3:0]      sel_strb;
    logic [31:0]     sel_wdata;

    assign req0 = m0_read_en | m0_write_en;
    assign req1 = m1_read_en | m1_write_en;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decode and selected-master mux, shared by next-state and output logic.
    always_comb begin
        gnt = 2'b00;
        if (hresetn) begin
            case (state_q)
                OWN0:    gnt = 2'b01;
                OWN1:    gnt = 2'b10;
                default: begin
                    if (req0 && req1)  gnt = last_q ? 2'b01 : 2'b10;
                    else if (req0)     gnt = 2'b01;
                    else if (req1)     gnt = 2'b10;
                end
            endcase
        end
        active    = |gnt;
        sel_req   = gnt[1] ? req1           : req0;
        sel_wr    = gnt[1] ? m1_write_en    : m0_write_en;
        sel_rd    = (gnt[1] ? m1_read_en    : m0_read_en) & ~sel_wr;
        sel_addr  = gnt[1] ? m1_addr        : m0_addr;
        sel_strb  = gnt[1] ? m1_byte_strobe : m0_byte_strobe;
        sel_wdata = gnt[1] ? m1_wdata       : m0_wdata;
        tmo       = (TIMEOUT > 0) && (state_q != IDLE) && sel_req && (cnt_q == CW'(TIMEOUT));
        done      = active && sel_req && (tmo || (sel_wr && s_wready) || (sel_rd && s_rready));
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (!active || !sel_req) begin
            // Idle, or owner withdrew its request: drop ownership without touching priority.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (done) begin
            state_d = IDLE;
            last_d  = gnt[1];
            cnt_d   = '0;
        end else begin
            state_d = gnt[1] ? OWN1 : OWN0;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_comb begin
        logic        wr_rdy, rd_rdy;
        logic [31:0] rdat;
        grant         = gnt;
        timeout_pulse = tmo;
        s_write_en    = active & sel_wr & ~tmo;
        s_read_en     = active & sel_rd & ~tmo;
        s_addr        = active ? sel_addr  : '0;
        s_byte_strobe = active ? sel_strb  : '0;
        s_wdata       = active ? sel_wdata : '0;
        wr_rdy        = sel_wr & (tmo | s_wready);
        rd_rdy        = sel_rd & (tmo | s_rready);
        rdat          = (tmo && sel_rd) ? ERR_RDATA : s_rdata;
        m0_wready     = gnt[0] & wr_rdy;
        m0_rready     = gnt[0] & rd_rdy;
        m0_rdata      = gnt[0] ? rdat : '0;
        m1_wready     = gnt[1] & wr_rdy;
        m1_rready     = gnt[1] & rd_rdy;
        m1_rdata      = gnt[1] ? rdat : '0;
    end

endmodule

// File: tb/tb_wrapper_reg_arbiter.sv
// Directed self-checking bench for wrapper_reg_arbiter, watchdog shortened to 4 cycles.
module tb_wrapper_reg_arbiter;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [11:0] m0_addr, m1_addr, s_addr;
    logic        m0_read_en, m0_write_en, m1_read_en, m1_write_en;
    logic [3:0]  m0_byte_strobe, m1_byte_strobe, s_byte_strobe;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic        m0_wready, m0_rready, m1_wready, m1_rready;
    logic        s_read_en, s_write_en, s_wready, s_rready;
    logic [1:0]  grant;
    logic        timeout_pulse;

    int unsigned tests = 0;
    int unsigned fails = 0;

    wrapper_reg_arbiter #(.ADDRWIDTH(12), .TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_addr(m0_addr), .m0_read_en(m0_read_en), .m0_write_en(m0_write_en),
        .m0_byte_strobe(m0_byte_strobe), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_wready(m0_wready), .m0_rready(m0_rready),
        .m1_addr(m1_addr), .m1_read_en(m1_read_en), .m1_write_en(m1_write_en),
        .m1_byte_strobe(m1_byte_strobe), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_wready(m1_wready), .m1_rready(m1_rready),
        .s_addr(s_addr), .s_read_en(s_read_en), .s_write_en(s_write_en),
        .s_byte_strobe(s_byte_strobe), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_wready(s_wready), .s_rready(s_rready),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic clear_masters();
        m0_read_en = 0; m0_write_en = 0; m0_addr = '0; m0_byte_strobe = '0; m0_wdata = '0;
        m1_read_en = 0; m1_write_en = 0; m1_addr = '0; m1_byte_strobe = '0; m1_wdata = '0;
    endtask

    logic [11:0] a0 [4];
    logic [11:0] a1 [4];
    int unsigned i0, i1;

    initial begin
        a0 = '{12'h100, 12'h104, 12'h108, 12'h10C};
        a1 = '{12'h200, 12'h204, 12'h208, 12'h20C};
        clear_masters();
        s_rdata = 32'hA5A5A5A5; s_wready = 1; s_rready = 1;
        hresetn = 0;

        // Reset: outputs quiet even with requests and target readies asserted
        m0_read_en = 1; m1_write_en = 1; m0_addr = 12'h123;
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_read_en", s_read_en, 0);
        chk("rst_s_write_en", s_write_en, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m0_rready", m0_rready, 0);
        chk("rst_m1_wready", m1_wready, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_timeout", timeout_pulse, 0);
        tick(); tick();
        hresetn = 1; clear_masters(); s_wready = 0; s_rready = 0;
        #2;
        chk("idle_grant", grant, 2'b00);
        tick();

        // Fairness: 4 reads each, alternating m0 first, one transfer per cycle
        i0 = 0; i1 = 0; s_rready = 1;
        for (int step = 0; step < 8; step++) begin
            m0_read_en = (i0 < 4); m0_addr = (i0 < 4) ? a0[i0] : '0;
            m1_read_en = (i1 < 4); m1_addr = (i1 < 4) ? a1[i1] : '0;
            s_rdata = (step % 2 == 0) ? {20'h0, a0[i0]} : {20'h0, a1[i1]};
            #2;
            if (step % 2 == 0) begin
                chk("fair_grant_m0", grant, 2'b01);
                chk("fair_s_addr_m0", s_addr, a0[i0]);
                chk("fair_m0_rready", m0_rready, 1);
                chk("fair_m0_rdata", m0_rdata, {20'h0, a0[i0]});
                chk("fair_m1_stall", m1_rready, 0);
                chk("fair_m1_rdata0", m1_rdata, 0);
                i0++;
            end else begin
                chk("fair_grant_m1", grant, 2'b10);
                chk("fair_s_addr_m1", s_addr, a1[i1]);
                chk("fair_m1_rready", m1_rready, 1);
                chk("fair_m1_rdata", m1_rdata, {20'h0, a1[i1]});
                chk("fair_m0_stall", m0_rready, 0);
                chk("fair_m0_rdata0", m0_rdata, 0);
                i1++;
            end
            tick();
        end
        clear_masters(); s_rready = 0;

        // Single write from m0, zero-cycle grant
        m0_write_en = 1; m0_addr = 12'h010; m0_wdata = 32'h12345678; m0_byte_strobe = 4'hF;
        s_wready = 1;
        #2;
        chk("wr_grant", grant, 2'b01);
        chk("wr_s_write_en", s_write_en, 1);
        chk("wr_s_read_en", s_read_en, 0);
        chk("wr_s_addr", s_addr, 12'h010);
        chk("wr_s_wdata", s_wdata, 32'h12345678);
        chk("wr_s_strobe", s_byte_strobe, 4'hF);
        chk("wr_m0_wready", m0_wready, 1);
        tick();
        clear_masters();
        #2;
        chk("wr_after_grant", grant, 2'b00);
        chk("wr_after_s_write_en", s_write_en, 0);
        chk("wr_after_s_wdata", s_wdata, 0);
        tick();

        // Hold: m1 write stalls 3 cycles, m0 read waits from cycle 2
        m1_write_en = 1; m1_addr = 12'h3A0; m1_wdata = 32'hCAFEF00D; m1_byte_strobe = 4'h3;
        s_wready = 0; s_rready = 1; s_rdata = 32'h000055AA;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin m0_read_en = 1; m0_addr = 12'h044; end
            if (c == 4) s_wready = 1;
            #2;
            chk("hold_grant", grant, 2'b10);
            chk("hold_s_addr", s_addr, 12'h3A0);
            chk("hold_s_write_en", s_write_en, 1);
            chk("hold_s_read_en", s_read_en, 0);
            chk("hold_m0_rready", m0_rready, 0);
            chk("hold_m1_wready", m1_wready, (c == 4));
            tick();
        end
        m1_write_en = 0; m1_addr = '0; s_wready = 0;
        #2;
        chk("hold_c5_grant", grant, 2'b01);
        chk("hold_c5_s_read_en", s_read_en, 1);
        chk("hold_c5_s_addr", s_addr, 12'h044);
        chk("hold_c5_m0_rready", m0_rready, 1);
        chk("hold_c5_m0_rdata", m0_rdata, 32'h000055AA);
        tick();
        clear_masters(); s_rready = 0;

        // Timeout: target never acknowledges a read
        m0_read_en = 1; m0_addr = 12'h080; s_rdata = 32'h11111111;
        for (int c = 1; c <= 4; c++) begin
            #2;
            chk("to_s_read_en", s_read_en, 1);
            chk("to_m0_rready", m0_rready, 0);
            chk("to_pulse_low", timeout_pulse, 0);
            tick();
        end
        #2;
        chk("to_c5_s_read_en", s_read_en, 0);
        chk("to_c5_m0_rready", m0_rready, 1);
        chk("to_c5_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("to_c5_pulse", timeout_pulse, 1);
        tick();
        clear_masters();
        #2;
        chk("to_c6_pulse", timeout_pulse, 0);
        chk("to_c6_grant", grant, 2'b00);
        tick();

        // Both enables: treated as a write
        m0_read_en = 1; m0_write_en = 1; m0_addr = 12'h0C0; s_wready = 1; s_rready = 0;
        #2;
        chk("both_s_write_en", s_write_en, 1);
        chk("both_s_read_en", s_read_en, 0);
        chk("both_m0_wready", m0_wready, 1);
        chk("both_m0_rready", m0_rready, 0);
        tick();
        clear_masters(); s_wready = 0;

        // Reset mid-transfer while m1 owns (m0 served last, so only reset restores m0 priority)
        m1_write_en = 1; m1_addr = 12'h2F0;
        #2;
        chk("rm_grant_c1", grant, 2'b10);
        tick();
        #2;
        chk("rm_grant_c2", grant, 2'b10);
        chk("rm_s_write_en_c2", s_write_en, 1);
        hresetn = 0;
        #1;
        chk("rm_grant_in_rst", grant, 2'b00);
        chk("rm_s_write_en_in_rst", s_write_en, 0);
        tick();
        hresetn = 1; clear_masters();
        #2;
        chk("rm_grant_after", grant, 2'b00);
        chk("rm_s_write_en_after", s_write_en, 0);
        chk("rm_s_read_en_after", s_read_en, 0);
        tick();
        m0_read_en = 1; m0_addr = 12'h001; m1_read_en = 1; m1_addr = 12'h002;
        #2;
        chk("rm_both_grant", grant, 2'b01);
        chk("rm_both_s_addr", s_addr, 12'h001);
        tick();
        clear_masters();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
